// File: rtl/rv_lsu_pkg.sv
// rtl/rv_lsu_pkg.sv - shared constants, FSM state type and decode helpers for rv_lsu
// Purpose: opcode/funct3 encodings, LSU FSM states, and the fault-decode
//          functions used at start acceptance.
// Ports:   none (package).
package rv_lsu_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } lsu_state_t;

    // Unsigned widths exist only for loads; everything else outside B/H/W is unsupported.
    function automatic logic f3_illegal(input logic is_load, input logic [2:0] f3);
        logic bad;
        case (f3)
            F3_B, F3_H, F3_W: bad = 1'b0;
            F3_BU, F3_HU:     bad = !is_load;
            default:          bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic bad;
        case (f3)
            F3_H, F3_HU: bad = a[0];
            F3_W:        bad = (a != 2'b00);
            default:     bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/rv_lsu_if.sv
// rtl/rv_lsu_if.sv - single-beat memory request/response bus between rv_lsu and memory
// Purpose: groups the valid/ready request and response-valid return.
// Signals: mem_req/mem_we/mem_addr/mem_wstrb/mem_wdata (master -> slave),
//          mem_ready/mem_rvalid/mem_rdata (slave -> master).
interface rv_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/rv_lsu_align.sv
// rtl/rv_lsu_align.sv - combinational store lane replication and load lane select/extend
// Purpose: maps store data onto byte lanes with strobes, and extracts/extends load data.
// Ports:   funct3, addr_lo (byte offset) in; wdata (store data), rdata (word read) in;
//          wstrb, wdata_lane (store lanes) out; load_data (writeback value) out.
module rv_lsu_align
    import rv_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data
);

    logic [31:0] rd_shift;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        rd_shift = rdata >> {addr_lo, 3'b000};
        rd_byte  = rd_shift[7:0];
        rd_half  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Store side: data is replicated to every lane so the strobe alone picks the target bytes.
    always_comb begin
        wstrb      = 4'b0000;
        wdata_lane = wdata;
        case (funct3)
            F3_B: begin
                wstrb      = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            F3_H: begin
                wstrb      = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
            end
            F3_W: wstrb = 4'b1111;
            default: ;
        endcase
    end

    always_comb begin
        load_data = rdata;
        case (funct3)
            F3_B:    load_data = {{24{rd_byte[7]}}, rd_byte};
            F3_BU:   load_data = {24'h0, rd_byte};
            F3_H:    load_data = {{16{rd_half[15]}}, rd_half};
            F3_HU:   load_data = {16'h0, rd_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/rv_lsu.sv
// rtl/rv_lsu.sv - RV32I load/store unit: one single-beat memory transaction per start
// Purpose: captures the memory op on start, issues the request, waits for read data,
//          and returns aligned/extended load data or a fault flag with a done pulse.
// Ports:   clk, rst (sync active-high); start, opcode, funct3, addr_in, wdata_in (op in);
//          busy, done, rd_data, rd_we, misalign, illegal (result out); mem (bus master).
module rv_lsu
    import rv_lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [31:0]       wdata_in,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rd_data,
    output logic              rd_we,
    output logic              misalign,
    output logic              illegal,
    rv_lsu_if.master          mem
);

    lsu_state_t state, state_next;

    logic              is_load_r;
    logic [2:0]        f3_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic [31:0]       rdata_r;
    logic              misalign_r;
    logic              illegal_r;

    logic start_load, start_store, accept, start_illegal, start_misalign;
    logic [3:0]  lane_wstrb;
    logic [31:0] lane_wdata, lane_load;

    always_comb begin
        start_load     = (opcode == OPC_LOAD);
        start_store    = (opcode == OPC_STORE);
        accept         = (state == S_IDLE) && start && (start_load || start_store);
        start_illegal  = f3_illegal(start_load, funct3);
        // An unsupported width has no meaningful alignment, so only legal ops can misalign.
        start_misalign = !start_illegal && addr_misaligned(funct3, addr_in[1:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_load_r  <= 1'b0;
            f3_r       <= 3'b000;
            addr_r     <= '0;
            wdata_r    <= 32'h0;
            rdata_r    <= 32'h0;
            misalign_r <= 1'b0;
            illegal_r  <= 1'b0;
        end else begin
            if (accept) begin
                is_load_r  <= start_load;
                f3_r       <= funct3;
                addr_r     <= addr_in;
                wdata_r    <= wdata_in;
                misalign_r <= start_misalign;
                illegal_r  <= start_illegal;
            end
            // Read data is only taken in WAIT; an rvalid during the handshake cycle is not a response.
            if (state == S_WAIT && mem.mem_rvalid) rdata_r <= mem.mem_rdata;
        end
    end

    rv_lsu_align u_align (
        .funct3     (f3_r),
        .addr_lo    (addr_r[1:0]),
        .wdata      (wdata_r),
        .rdata      (rdata_r),
        .wstrb      (lane_wstrb),
        .wdata_lane (lane_wdata),
        .load_data  (lane_load)
    );

    always_comb begin
        state_next    = state;
        busy          = (state != S_IDLE);
        done          = 1'b0;
        rd_data       = 32'h0;
        rd_we         = 1'b0;
        misalign      = 1'b0;
        illegal       = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wstrb = 4'b0000;
        mem.mem_wdata = 32'h0;
        case (state)
            S_IDLE: begin
                if (accept) state_next = (start_illegal || start_misalign) ? S_RESP : S_REQ;
            end
            S_REQ: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = !is_load_r;
                mem.mem_addr  = {addr_r[ADDR_W-1:2], 2'b00};
                mem.mem_wstrb = is_load_r ? 4'b0000 : lane_wstrb;
                mem.mem_wdata = is_load_r ? 32'h0 : lane_wdata;
                if (mem.mem_ready) state_next = is_load_r ? S_WAIT : S_RESP;
            end
            S_WAIT: begin
                if (mem.mem_rvalid) state_next = S_RESP;
            end
            S_RESP: begin
                done     = 1'b1;
                misalign = misalign_r;
                illegal  = illegal_r;
                if (is_load_r && !misalign_r && !illegal_r) begin
                    rd_we   = 1'b1;
                    rd_data = lane_load;
                end
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rv_lsu.sv
// tb/tb_rv_lsu.sv - directed self-checking bench for rv_lsu
module tb_rv_lsu;

    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic        busy, done, rd_we, misalign, illegal;
    logic [31:0] rd_data;

    int tests = 0;
    int fails = 0;

    rv_lsu_if #(.ADDR_W(32)) bus ();

    rv_lsu #(.ADDR_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .opcode   (opcode),
        .funct3   (funct3),
        .addr_in  (addr_in),
        .wdata_in (wdata_in),
        .busy     (busy),
        .done     (done),
        .rd_data  (rd_data),
        .rd_we    (rd_we),
        .misalign (misalign),
        .illegal  (illegal),
        .mem      (bus)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; opcode = 7'h0; funct3 = 3'h0; addr_in = 32'h0; wdata_in = 32'h0;
        bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
        @(negedge clk); @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
        tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b expected 0", bus.mem_req); end
        tests++; if ({rd_we, misalign, illegal, bus.mem_we, bus.mem_wstrb} !== 8'h00) begin fails++; $display("FAIL reset_flags: got %h expected 00", {rd_we, misalign, illegal, bus.mem_we, bus.mem_wstrb}); end
        tests++; if ({rd_data, bus.mem_addr, bus.mem_wdata} !== 96'h0) begin fails++; $display("FAIL reset_data: got %h expected 0", {rd_data, bus.mem_addr, bus.mem_wdata}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] exp_addr, input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
        opcode = ST; funct3 = f3; addr_in = a; wdata_in = wd; start = 1'b1; bus.mem_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; wdata_in = 32'h0; addr_in = 32'hFFFF_FFFF;
        tests++; if ({bus.mem_req, bus.mem_we, busy, done} !== 4'b1110) begin fails++; $display("FAIL %s_c1_ctl: got %b expected 1110", tag, {bus.mem_req, bus.mem_we, busy, done}); end
        tests++; if (bus.mem_addr !== exp_addr) begin fails++; $display("FAIL %s_addr: got %h expected %h", tag, bus.mem_addr, exp_addr); end
        tests++; if (bus.mem_wstrb !== exp_strb) begin fails++; $display("FAIL %s_wstrb: got %b expected %b", tag, bus.mem_wstrb, exp_strb); end
        tests++; if (bus.mem_wdata !== exp_wdata) begin fails++; $display("FAIL %s_wdata: got %h expected %h", tag, bus.mem_wdata, exp_wdata); end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        tests++; if ({done, rd_we, bus.mem_req, misalign, illegal} !== 5'b10000) begin fails++; $display("FAIL %s_c2_done: got %b expected 10000", tag, {done, rd_we, bus.mem_req, misalign, illegal}); end
        tests++; if (rd_data !== 32'h0) begin fails++; $display("FAIL %s_rd_data: got %h expected 0", tag, rd_data); end
        @(negedge clk);
        tests++; if ({busy, done} !== 2'b00) begin fails++; $display("FAIL %s_c3_idle: got %b expected 00", tag, {busy, done}); end
    endtask

    task automatic test_load(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata,
                             input logic [31:0] exp_addr, input logic [31:0] exp, input int gap);
        opcode = LD; funct3 = f3; addr_in = a; wdata_in = 32'hFFFF_FFFF; start = 1'b1; bus.mem_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; addr_in = ~a;
        tests++; if ({bus.mem_req, bus.mem_we, bus.mem_wstrb} !== 6'b100000) begin fails++; $display("FAIL %s_c1_ctl: got %b expected 100000", tag, {bus.mem_req, bus.mem_we, bus.mem_wstrb}); end
        tests++; if (bus.mem_addr !== exp_addr) begin fails++; $display("FAIL %s_addr: got %h expected %h", tag, bus.mem_addr, exp_addr); end
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        tests++; if ({bus.mem_req, busy, done} !== 3'b010) begin fails++; $display("FAIL %s_c2_wait: got %b expected 010", tag, {bus.mem_req, busy, done}); end
        if (gap > 1) begin
            bus.mem_rvalid = 1'b0;
            @(negedge clk);
            tests++; if (done !== 1'b0) begin fails++; $display("FAIL %s_early_done: got %b expected 0", tag, done); end
        end
        bus.mem_rvalid = 1'b1; bus.mem_rdata = rdata;
        @(negedge clk);
        bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
        tests++; if ({done, rd_we, misalign, illegal} !== 4'b1100) begin fails++; $display("FAIL %s_done: got %b expected 1100", tag, {done, rd_we, misalign, illegal}); end
        tests++; if (rd_data !== exp) begin fails++; $display("FAIL %s_rd_data: got %h expected %h", tag, rd_data, exp); end
        @(negedge clk);
        tests++; if ({busy, done, rd_we, rd_data} !== 35'h0) begin fails++; $display("FAIL %s_after: got %h expected 0", tag, {busy, done, rd_we, rd_data}); end
    endtask

    task automatic test_fault(input string tag, input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                              input logic exp_mis, input logic exp_ill);
        opcode = op; funct3 = f3; addr_in = a; wdata_in = 32'h1234_5678; start = 1'b1; bus.mem_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests++; if ({done, misalign, illegal} !== {1'b1, exp_mis, exp_ill}) begin fails++; $display("FAIL %s_flags: got %b expected %b", tag, {done, misalign, illegal}, {1'b1, exp_mis, exp_ill}); end
        tests++; if ({bus.mem_req, rd_we, rd_data} !== 34'h0) begin fails++; $display("FAIL %s_no_access: got %h expected 0", tag, {bus.mem_req, rd_we, rd_data}); end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        tests++; if ({busy, done, bus.mem_req} !== 3'b000) begin fails++; $display("FAIL %s_after: got %b expected 000", tag, {busy, done, bus.mem_req}); end
    endtask

    task automatic test_bad_opcode();
        opcode = 7'b0110011; funct3 = 3'b010; addr_in = 32'h100; start = 1'b1; bus.mem_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; bus.mem_ready = 1'b0;
        tests++; if ({busy, done, bus.mem_req} !== 3'b000) begin fails++; $display("FAIL bad_opcode: got %b expected 000", {busy, done, bus.mem_req}); end
        @(negedge clk);
    endtask

    task automatic test_sw_stall();
        opcode = ST; funct3 = 3'b010; addr_in = 32'h6004; wdata_in = 32'hCAFE_F00D; start = 1'b1; bus.mem_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tests++; if ({bus.mem_req, bus.mem_we, bus.mem_wstrb, done, busy} !== 8'b11111101) begin fails++; $display("FAIL stall_ctl_c%0d: got %b expected 11111101", c, {bus.mem_req, bus.mem_we, bus.mem_wstrb, done, busy}); end
            tests++; if ({bus.mem_addr, bus.mem_wdata} !== {32'h6004, 32'hCAFE_F00D}) begin fails++; $display("FAIL stall_data_c%0d: got %h expected 00006004cafef00d", c, {bus.mem_addr, bus.mem_wdata}); end
            start = (c == 3); opcode = LD; addr_in = 32'h7000; wdata_in = 32'h0;
            @(negedge clk);
        end
        start = 1'b0; bus.mem_ready = 1'b1;
        tests++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h6004}) begin fails++; $display("FAIL stall_ready_cyc: got %h expected 100006004", {bus.mem_req, bus.mem_addr}); end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        tests++; if ({done, bus.mem_req} !== 2'b10) begin fails++; $display("FAIL stall_done: got %b expected 10", {done, bus.mem_req}); end
        @(negedge clk);
        tests++; if ({busy, done, bus.mem_req} !== 3'b000) begin fails++; $display("FAIL stall_ignored_start: got %b expected 000", {busy, done, bus.mem_req}); end
    endtask

    task automatic test_back_to_back();
        opcode = ST; funct3 = 3'b010; addr_in = 32'h8000; wdata_in = 32'h0102_0304; start = 1'b1; bus.mem_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_first_done: got %b expected 1", done); end
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle_gap: got %b expected 0", busy); end
        funct3 = 3'b000; addr_in = 32'h8001; wdata_in = 32'h0000_005A; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests++; if ({bus.mem_req, bus.mem_wstrb, bus.mem_wdata} !== {1'b1, 4'b0010, 32'h5A5A_5A5A}) begin fails++; $display("FAIL b2b_second_req: got %h expected 125a5a5a5a", {bus.mem_req, bus.mem_wstrb, bus.mem_wdata}); end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_second_done: got %b expected 1", done); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        opcode = ST; funct3 = 3'b010; addr_in = 32'hA000; wdata_in = 32'h1; start = 1'b1; bus.mem_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++; if ({bus.mem_req, busy} !== 2'b00) begin fails++; $display("FAIL rst_in_req: got %b expected 00", {bus.mem_req, busy}); end
        opcode = LD; funct3 = 3'b010; addr_in = 32'h9000; start = 1'b1; bus.mem_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rst_wait_busy: got %b expected 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++; if ({busy, done, rd_we, bus.mem_req, rd_data} !== 36'h0) begin fails++; $display("FAIL rst_in_wait: got %h expected 0", {busy, done, rd_we, bus.mem_req, rd_data}); end
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        tests++; if ({done, rd_we, busy} !== 3'b000) begin fails++; $display("FAIL rst_late_rvalid: got %b expected 000", {done, rd_we, busy}); end
        @(negedge clk);
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_late_rvalid2: got %b expected 0", done); end
    endtask

    initial begin
        test_reset();
        test_store("sb_1003", 3'b000, 32'h1003, 32'h0000_00A5, 32'h1000, 4'b1000, 32'hA5A5_A5A5);
        test_store("sb_1001", 3'b000, 32'h1001, 32'hFFFF_FF3C, 32'h1000, 4'b0010, 32'h3C3C_3C3C);
        test_store("sh_0002", 3'b001, 32'h0002, 32'h1234_ABCD, 32'h0000, 4'b1100, 32'hABCD_ABCD);
        test_store("sh_0000", 3'b001, 32'h0000, 32'h1234_ABCD, 32'h0000, 4'b0011, 32'hABCD_ABCD);
        test_load("lb_2001", 3'b000, 32'h2001, 32'h0000_8000, 32'h2000, 32'hFFFF_FF80, 2);
        test_load("lbu_2001", 3'b100, 32'h2001, 32'h0000_8000, 32'h2000, 32'h0000_0080, 2);
        test_load("lh_3002", 3'b001, 32'h3002, 32'h8001_1234, 32'h3000, 32'hFFFF_8001, 2);
        test_load("lhu_3002", 3'b101, 32'h3002, 32'h8001_1234, 32'h3000, 32'h0000_8001, 2);
        test_load("lw_4000", 3'b010, 32'h4000, 32'h1234_5678, 32'h4000, 32'h1234_5678, 1);
        test_load("lb_5003", 3'b000, 32'h5003, 32'h7F00_0000, 32'h5000, 32'h0000_007F, 1);
        test_fault("lw_mis", LD, 3'b010, 32'h4002, 1'b1, 1'b0);
        test_fault("sh_mis", ST, 3'b001, 32'h4001, 1'b1, 1'b0);
        test_fault("sbu_ill", ST, 3'b100, 32'h0100, 1'b0, 1'b1);
        test_fault("l011_ill", LD, 3'b011, 32'h0100, 1'b0, 1'b1);
        test_bad_opcode();
        test_sw_stall();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rv_lsu.md
# rv_lsu

Load/store unit for the RV32I core. Sits downstream of `rv_alu`: when the ALU flags a memory instruction (`addr` = 1), the ALU result is the effective address. This block turns that address plus `funct3` into a single-beat memory transaction with a valid/ready request and a response-valid return. On completion it returns aligned, extended load data for register writeback and holds the pipeline via `busy`.

## Interface
Parameters:
- `ADDR_W`, 32, memory address width; `mem_addr` is always word-aligned.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  pulse: launch the memory op described by the current inputs; sampled only in IDLE.
- `opcode`  in  7  `7'b0000011` = load, `7'b0100011` = store; any other value with `start` is ignored.
- `funct3`  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU (load only), 101 HU (load only).
- `addr_in`  in  ADDR_W  effective address (ALU `Rd`).
- `wdata_in`  in  32  store data (`Rs2`).
- `busy`  out  1  high from the cycle after an accepted `start` until `done` has been issued.
- `done`  out  1  one-cycle completion pulse.
- `rd_data`  out  32  load result; valid only with `done` for a load; otherwise 0.
- `rd_we`  out  1  asserted with `done` for a fault-free load only.
- `misalign`  out  1  asserted with `done` when H is at an odd address or W has `addr_in[1:0]` != 0.
- `illegal`  out  1  asserted with `done` for an unsupported `funct3` (011, 110, 111; 100/101 on a store).
- `mem_req`  out  1  request valid.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  ADDR_W  `{addr_in[ADDR_W-1:2],2'b00}`.
- `mem_wstrb`  out  4  byte-lane enables; 0 on reads.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ready`  in  1  responder accepts when `mem_req && mem_ready` at a clock edge.
- `mem_rvalid`  in  1  read-data valid.
- `mem_rdata`  in  32  read data.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
  - IDLE -> REQ on a legal, aligned `start`.
  - IDLE -> RESP on `start` with a fault (`misalign`/`illegal`); no memory access is made.
  - REQ -> WAIT (load) or RESP (store) on handshake.
  - WAIT -> RESP on `mem_rvalid`.
  - RESP -> IDLE always.
- All inputs (`opcode`, `funct3`, `addr_in[1:0]`, `wdata_in`) are registered on the accepted `start`. Later input changes have no effect.
- `mem_req`, `mem_we`, `mem_addr`, `mem_wstrb`, and `mem_wdata` are held stable in REQ until the handshake. They are 0 outside REQ.
- Store lanes:
  - SB: `mem_wdata = {4{b}}`, `wstrb = 4'b0001 << a[1:0]`.
  - SH: `mem_wdata = {2{h}}`, `wstrb` = 0011 or 1100 by `a[1]`.
  - SW: `wstrb` = 1111.
- Loads: select byte `a[1:0]` or half `a[1]` from the captured `mem_rdata`. B/H sign-extend from bit 7/15; BU/HU zero-extend.
- `start` while `busy` is ignored, with no queueing.
- Reset values: state IDLE; all outputs 0.
- Reset mid-operation returns to IDLE and drops `mem_req` at the same edge. A late `mem_rvalid` after that is ignored.

## Timing
- Cycle 0: `start` sampled. Cycle 1: REQ, `mem_req` = 1, `busy` = 1.
- Store with `mem_ready` = 1: `done` in cycle 2. This is the minimum latency, 2 cycles.
- Load with `mem_ready` = 1 in cycle 1 and `mem_rvalid` in cycle 2: `done`/`rd_data` in cycle 3. This is the minimum latency, 3 cycles.
- `mem_rvalid` in the same cycle as the request handshake is not sampled. The responder returns data at least 1 cycle after acceptance.
- Faulting op: `done` plus the flag in cycle 1.
- `busy` drops in the cycle after `done`. The next `start` is accepted in that IDLE cycle, giving back-to-back throughput of 1 op per (latency + 1) cycles.

## Structure
- `rv_lsu_pkg`:
  - `OPC_LOAD` and `OPC_STORE` constants.
  - `F3_B/H/W/BU/HU` constants.
  - FSM state enum.
- Sub-module `rv_lsu_align`: combinational store lane replication/strobe generation and load lane select/extension. Instantiated once; the FSM stays in `rv_lsu`.

## Test plan
- SB `addr_in`=0x1003, `wdata_in`=0xA5, `mem_ready`=1 -> cycle 1: `mem_addr`=0x1000, `wstrb`=1000, `wdata`=0xA5A5A5A5; `done` cycle 2, `rd_we`=0.
- LB at 0x2001, `mem_rdata`=0x00008000 returned 2 cycles after acceptance -> `rd_data`=0xFFFFFF80, `rd_we`=1. LBU at the same address -> `rd_data`=0x00000080.
- LH at 0x3002, `mem_rdata`=0x8001_1234 -> `rd_data`=0xFFFF8001. LHU -> `rd_data`=0x00008001.
- LW at 0x4002 -> `done`+`misalign` in cycle 1, `mem_req` never asserted. Store with `funct3`=100 -> `done`+`illegal`.
- SW with `mem_ready` low for 5 cycles -> `mem_req`/`addr`/`wdata` stable throughout. A `start` pulse mid-wait is ignored. `done` occurs 1 cycle after the ready edge.
- LW in WAIT, `rst` asserted -> next cycle IDLE with all outputs 0. A subsequent `mem_rvalid` produces no `done`.
